pipelined_addsub: RTL and testbench

//   Parametrised, pipelined adder/subtractor for the MIPS datapath and divider.

---
 rtl/pipelined_addsub.sv | 140 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one carry-chained slice per stage, global valid/ready stall.
// Define ADDSUB_SAT_EN to saturate the sum to the signed limit on overflow (default: wrap).
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SW   = WIDTH / STAGES;
    localparam int NMID = (STAGES > 1) ? STAGES - 1 : 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Stages 0..STAGES-2 hold operands, partial result and slice carry; the last stage is the output register.
    logic [NMID-1:0]  mid_valid_q, mid_valid_d;
    logic [NMID-1:0]  mid_carry_q, mid_carry_d;
    logic [WIDTH-1:0] mid_a_q   [NMID];
    logic [WIDTH-1:0] mid_a_d   [NMID];
    logic [WIDTH-1:0] mid_bx_q  [NMID];
    logic [WIDTH-1:0] mid_bx_d  [NMID];
    logic [WIDTH-1:0] mid_res_q [NMID];
    logic [WIDTH-1:0] mid_res_d [NMID];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             en;

    always_comb begin
        logic [WIDTH-1:0] op_a, op_bx, res;
        logic             c_in, v_in, c_msb;
        logic [SW:0]      slice;

        // NOTE: every output of this block gets a default first, so no path through it can infer a latch.
        en          = out_ready | ~out_valid_q;
        mid_valid_d = mid_valid_q;
        mid_carry_d = mid_carry_q;
        mid_a_d     = mid_a_q;
        mid_bx_d    = mid_bx_q;
        mid_res_d   = mid_res_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;

        op_a  = a;
        op_bx = b ^ {WIDTH{sub}};
        res   = '0;
        c_in  = sub;
        v_in  = in_valid & en;
        slice = '0;
        c_msb = 1'b0;

        if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                if (k > 0) begin
                    op_a  = mid_a_q[k-1];
                    op_bx = mid_bx_q[k-1];
                    res   = mid_res_q[k-1];
                    c_in  = mid_carry_q[k-1];
                    v_in  = mid_valid_q[k-1];
                end
                slice = {1'b0, op_a[k*SW +: SW]} + {1'b0, op_bx[k*SW +: SW]} + {{SW{1'b0}}, c_in};
                res[k*SW +: SW] = slice[SW-1:0];

                if (k < STAGES - 1) begin
                    mid_valid_d[k] = v_in;
                    mid_carry_d[k] = slice[SW];
                    mid_a_d[k]     = op_a;
                    mid_bx_d[k]    = op_bx;
                    mid_res_d[k]   = res;
                end else begin
                    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
                    c_msb       = res[WIDTH-1] ^ op_a[WIDTH-1] ^ op_bx[WIDTH-1];
                    out_valid_d = v_in;
                    cout_d      = slice[SW];
                    ovf_d       = c_msb ^ slice[SW];
`ifdef ADDSUB_SAT_EN
                    if (ovf_d) begin
                        res = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                    sum_d  = res;
                    zero_d = (res == '0);
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mid_valid_q <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            mid_valid_q <= mid_valid_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    // NOTE: the data path has no reset; its contents are ignored until the matching valid bit is set.
    always_ff @(posedge clk) begin
        mid_carry_q <= mid_carry_d;
        mid_a_q     <= mid_a_d;
        mid_bx_q    <= mid_bx_d;
        mid_res_q   <= mid_res_d;
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: STAGES = 2, 1, 4, 8 run in parallel against one arithmetic model.
// Directed spec vectors, a stalled 8-op stream, randomized traffic and a mid-flight reset per configuration.
`timescale 1ns/1ps
module tb_pipelined_addsub;
    localparam int W    = 32;
    localparam int NCFG = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide unsigned and signed arithmetic.
    function automatic res_t model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rs);
        res_t   r;
        longint ua, ub, sa, sb, full, sres;
        ua   = longint'({32'b0, ra});
        ub   = longint'({32'b0, rb});
        sa   = longint'($signed(ra));
        sb   = longint'($signed(rb));
        full = rs ? ua - ub : ua + ub;
        sres = rs ? sa - sb : sa + sb;
        r.sum  = full[W-1:0];
        r.cout = rs ? (ua >= ub) : (full >= (longint'(1) << W));
        r.ovf  = (sres > (longint'(1) << (W - 1)) - 1) || (sres < -(longint'(1) << (W - 1)));
`ifdef ADDSUB_SAT_EN
        if (r.ovf) r.sum = (sres > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        r.zero = (r.sum == '0);
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'd1;
            default: return $urandom();
        endcase
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int S = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 4 : 8;

        logic         rst_n, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
        logic [W-1:0] a, b, sum;
        res_t         exp_q[$];
        int           n_out;
        bit           fin = 1'b0;

        pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk      (clk),
            .reset_n  (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .sum      (sum),
            .cout     (cout),
            .ovf      (ovf),
            .zero     (zero)
        );

        function automatic string tg(input string s);
            return $sformatf("S%0d %s", S, s);
        endfunction

        // One clock, entered at a negedge with inputs driven; scoreboards both handshakes mid-cycle.
        task automatic step(output bit acc);
            res_t e;
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                n_out++;
                check(tg("result pending"), exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check(tg("sum"), sum, e.sum);
                    check(tg("cout"), cout, e.cout);
                    check(tg("ovf"), ovf, e.ovf);
                    check(tg("zero"), zero, e.zero);
                end
            end
            if (acc) exp_q.push_back(model(a, b, sub));
            @(negedge clk);
        endtask

        task automatic drain(input string what);
            bit acc;
            int n = 0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            while ((exp_q.size() > 0 || out_valid) && n < 100) begin
                step(acc);
                n++;
            end
            check(tg({what, " drained"}), exp_q.size(), 0);
            check(tg({what, " idle"}), out_valid, 0);
        endtask

        task automatic directed(input string name, input logic [W-1:0] da, input logic [W-1:0] db,
                                input logic ds, input logic [W-1:0] esum, input logic ecout,
                                input logic eovf, input logic ezero);
            int n;
            a = da; b = db; sub = ds;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1 check(tg({name, " in_ready"}), in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < S + 4) begin
                @(negedge clk);
                n++;
            end
            check(tg({name, " latency"}), n, S);
            check(tg({name, " sum"}), sum, esum);
            check(tg({name, " cout"}), cout, ecout);
            check(tg({name, " ovf"}), ovf, eovf);
            check(tg({name, " zero"}), zero, ezero);
            @(negedge clk);
            check(tg({name, " consumed"}), out_valid, 0);
        endtask

        initial begin
            bit           acc, stall, prev_stall, seen;
            int           sent, cyc, outs0;
            logic [W-1:0] prev_sum;

            rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            a = '0; b = '0; sub = 1'b0; n_out = 0;
            repeat (2) @(negedge clk);
            check(tg("reset out_valid"), out_valid, 0);
            check(tg("reset sum"), sum, 0);
            check(tg("reset cout"), cout, 0);
            check(tg("reset ovf"), ovf, 0);
            check(tg("reset zero"), zero, 0);
            rst_n = 1'b1;
            @(negedge clk);
            check(tg("idle in_ready"), in_ready, 1);

            directed("ffff+1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
            directed("5-7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
            directed("max+1", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
            directed("min-1", 32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
            directed("max+1", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
            directed("min-1", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif

            // 8 back-to-back ops with a 3-cycle consumer stall once results are flowing.
            n_out = 0; sent = 0; cyc = 0;
            prev_stall = 1'b0; prev_sum = '0;
            a = pick(); b = pick(); sub = 1'($urandom_range(0, 1));
            while ((sent < 8 || exp_q.size() > 0) && cyc < 100) begin
                stall     = (cyc >= S) && (cyc < S + 3);
                out_ready = !stall;
                in_valid  = (sent < 8);
                #1;
                if (stall) begin
                    check(tg("stall in_ready"), in_ready, 0);
                    check(tg("stall out_valid"), out_valid, 1);
                    if (prev_stall) check(tg("stall sum held"), sum, prev_sum);
                end
                prev_stall = stall;
                prev_sum   = sum;
                step(acc);
                if (acc) begin
                    sent++;
                    a = pick(); b = pick(); sub = 1'($urandom_range(0, 1));
                end
                cyc++;
            end
            check(tg("stream results"), n_out, 8);
            drain("stream");

            // Randomized traffic with random back-pressure; operands held while not accepted.
            sent = 0; cyc = 0; in_valid = 1'b0;
            while (sent < 200 && cyc < 2000) begin
                if (!in_valid) begin
                    a = pick(); b = pick(); sub = 1'($urandom_range(0, 1));
                    in_valid = ($urandom_range(0, 3) != 0);
                end
                out_ready = ($urandom_range(0, 9) < 7);
                step(acc);
                if (acc) begin
                    sent++;
                    in_valid = 1'b0;
                end
                cyc++;
            end
            check(tg("random ops accepted"), sent, 200);
            drain("random");

            // Reset with operations in flight: nothing stale may emerge afterwards.
            out_ready = 1'b0;
            in_valid  = 1'b1;
            repeat (2) begin
                a = pick(); b = pick(); sub = 1'($urandom_range(0, 1));
                step(acc);
            end
            in_valid = 1'b0;
            rst_n    = 1'b0;
            #1 check(tg("reset flush out_valid"), out_valid, 0);
            exp_q.delete();
            @(negedge clk);
            rst_n     = 1'b1;
            out_ready = 1'b1;
            seen      = 1'b0;
            repeat (2 * S + 4) begin
                #1 if (out_valid) seen = 1'b1;
                @(negedge clk);
            end
            check(tg("no stale result"), seen, 0);
            outs0    = n_out;
            a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b1;
            in_valid = 1'b1;
            step(acc);
            check(tg("post-reset accept"), acc, 1);
            drain("post-reset");
            check(tg("post-reset results"), n_out - outs0, 1);

            fin = 1'b1;
        end
    end

    initial begin
        int t = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && t < 40000) begin
            @(posedge clk);
            t++;
        end
        check("all configs finished",
              {g_cfg[3].fin, g_cfg[2].fin, g_cfg[1].fin, g_cfg[0].fin}, 4'b1111);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
